// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg : key codes, FSM states and opcode encoding for the calculator
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_MUL = 4'd12;
    localparam logic [3:0] KEY_DIV = 4'd13;
    localparam logic [3:0] KEY_CLR = 4'd14;
    localparam logic [3:0] KEY_EQ  = 4'd15;

    typedef enum logic [2:0] {
        ST_ENTRY_A = 3'd0,
        ST_ENTRY_B = 3'd1,
        ST_DIV     = 3'd2,
        ST_RESULT  = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

    // Operator keys 10..13 map onto 0..3 by subtracting 2 in the low two bits.
    function automatic op_t key_to_op(input logic [3:0] key);
        return op_t'(key[1:0] - 2'd2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/calc_divider.sv
// ---------------------------------------------------------------------------
// calc_divider : restoring unsigned divider, one quotient bit per cycle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module calc_divider #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic [WIDTH-1:0] quotient,
    output logic             done
);

    localparam int              CW            = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   c_cnt_last    = CW'(WIDTH);
    localparam logic [CW-1:0]   c_cnt_prelast = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_src_rem;
    logic [WIDTH-1:0] w_src_quo;
    logic [WIDTH-1:0] w_src_div;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_quo_nx;

    // The first iteration runs on the start cycle straight from the inputs,
    // so the last quotient bit is ready while busy is still high.
    assign w_src_rem = start ? '0       : r_rem;
    assign w_src_quo = start ? dividend : r_quo;
    assign w_src_div = start ? divisor  : r_div;
    assign w_shift   = {w_src_rem, w_src_quo[WIDTH-1]};
    assign w_ge      = (w_shift >= {1'b0, w_src_div});
    assign w_rem_nx  = w_ge ? WIDTH'(w_shift - {1'b0, w_src_div}) : w_shift[WIDTH-1:0];
    assign w_quo_nx  = {w_src_quo[WIDTH-2:0], w_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start && !r_busy) begin
                r_busy <= 1'b1;
                r_rem  <= w_rem_nx;
                r_quo  <= w_quo_nx;
                r_div  <= divisor;
                r_cnt  <= CW'(1);
            end else if (r_busy) begin
                if (r_cnt == c_cnt_last) begin
                    r_busy <= 1'b0;
                end else begin
                    r_rem  <= w_rem_nx;
                    r_quo  <= w_quo_nx;
                    r_cnt  <= r_cnt + CW'(1);
                    r_done <= (r_cnt == c_cnt_prelast);
                end
            end
        end
    end

    assign busy     = r_busy;
    assign quotient = r_quo;
    assign done     = r_done;

endmodule

`default_nettype wire

// File: rtl/calc_core.sv
// ---------------------------------------------------------------------------
// calc_core : keypad calculator core with chaining, clear and error latching
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module calc_core
    import calc_pkg::*;
#(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic [WIDTH-1:0] bin_data,
    output logic             busy,
    output logic             err,
    output logic             done
);

    localparam int EW = WIDTH + 4;

    state_t           r_state;
    op_t              r_opcode;
    logic [WIDTH-1:0] r_num1;
    logic [WIDTH-1:0] r_bin_data;
    logic             r_b_seen;
    logic             r_chain;
    logic             r_err;
    logic             r_done;

    logic             w_is_digit;
    logic             w_is_op;
    logic             w_is_clr;
    op_t              w_key_op;
    logic [EW-1:0]    w_digit_ext;
    logic             w_digit_fits;
    logic [WIDTH:0]   w_sum;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_err;
    logic             w_div_start;
    logic             w_div_busy;
    logic             w_div_done;
    logic [WIDTH-1:0] w_quot;

    assign w_is_digit = (key_code < 4'd10);
    assign w_is_op    = (key_code >= KEY_ADD) && (key_code <= KEY_DIV);
    assign w_is_clr   = (key_code == KEY_CLR);
    assign w_key_op   = key_to_op(key_code);

    // Digit is accepted only if value*10+d still fits in WIDTH bits.
    assign w_digit_ext  = EW'(r_bin_data) * EW'(10) + EW'(key_code);
    assign w_digit_fits = (w_digit_ext[EW-1:WIDTH] == 4'd0);

    assign w_sum  = {1'b0, r_num1} + {1'b0, r_bin_data};
    assign w_prod = {{WIDTH{1'b0}}, r_num1} * {{WIDTH{1'b0}}, r_bin_data};

    always_comb begin
        w_alu_res = '0;
        w_alu_err = 1'b0;
        case (r_opcode)
            OP_ADD: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_err = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_alu_res = r_num1 - r_bin_data;
                w_alu_err = (r_num1 < r_bin_data);
            end
            OP_MUL: begin
                w_alu_res = w_prod[WIDTH-1:0];
                w_alu_err = (w_prod[2*WIDTH-1:WIDTH] != '0);
            end
            default: begin
                w_alu_err = (r_bin_data == '0);
            end
        endcase
    end

    assign w_div_start = key_valid && (r_state == ST_ENTRY_B) && r_b_seen
                       && (w_is_op || (key_code == KEY_EQ))
                       && (r_opcode == OP_DIV) && (r_bin_data != '0);

    calc_divider #(
        .WIDTH (WIDTH)
    ) u_divider (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w_div_start),
        .dividend (r_num1),
        .divisor  (r_bin_data),
        .busy     (w_div_busy),
        .quotient (w_quot),
        .done     (w_div_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_ENTRY_A;
            r_opcode   <= OP_ADD;
            r_num1     <= '0;
            r_bin_data <= '0;
            r_b_seen   <= 1'b0;
            r_chain    <= 1'b0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_DIV) begin
                if (w_div_done) begin
                    r_done <= 1'b1;
                    r_chain <= 1'b0;
                    if (r_chain) begin
                        r_num1     <= w_quot;
                        r_bin_data <= '0;
                        r_b_seen   <= 1'b0;
                        r_state    <= ST_ENTRY_B;
                    end else begin
                        r_bin_data <= w_quot;
                        r_state    <= ST_RESULT;
                    end
                end
            end else if (key_valid) begin
                if (w_is_clr) begin
                    r_bin_data <= '0;
                    r_num1     <= '0;
                    r_opcode   <= OP_ADD;
                    r_b_seen   <= 1'b0;
                    r_chain    <= 1'b0;
                    r_err      <= 1'b0;
                    r_state    <= ST_ENTRY_A;
                end else if (w_is_digit) begin
                    if (r_state == ST_ENTRY_A || r_state == ST_ENTRY_B) begin
                        if (w_digit_fits) begin
                            r_bin_data <= w_digit_ext[WIDTH-1:0];
                        end
                        if (r_state == ST_ENTRY_B) begin
                            r_b_seen <= 1'b1;
                        end
                    end else begin
                        r_bin_data <= WIDTH'(key_code);
                        r_err      <= 1'b0;
                        r_state    <= ST_ENTRY_A;
                    end
                end else if (w_is_op) begin
                    case (r_state)
                        ST_ENTRY_A, ST_RESULT: begin
                            r_num1     <= r_bin_data;
                            r_opcode   <= w_key_op;
                            r_bin_data <= '0;
                            r_b_seen   <= 1'b0;
                            r_state    <= ST_ENTRY_B;
                        end
                        ST_ENTRY_B: begin
                            if (!r_b_seen) begin
                                r_opcode <= w_key_op;
                            end else if (w_alu_err) begin
                                r_err      <= 1'b1;
                                r_bin_data <= '0;
                                r_done     <= 1'b1;
                                r_state    <= ST_ERROR;
                            end else if (r_opcode == OP_DIV) begin
                                r_chain  <= 1'b1;
                                r_opcode <= w_key_op;
                                r_state  <= ST_DIV;
                            end else begin
                                r_num1     <= w_alu_res;
                                r_bin_data <= '0;
                                r_opcode   <= w_key_op;
                                r_b_seen   <= 1'b0;
                                r_done     <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end else if (r_state == ST_ENTRY_B && r_b_seen) begin
                    if (w_alu_err) begin
                        r_err      <= 1'b1;
                        r_bin_data <= '0;
                        r_done     <= 1'b1;
                        r_state    <= ST_ERROR;
                    end else if (r_opcode == OP_DIV) begin
                        r_chain <= 1'b0;
                        r_state <= ST_DIV;
                    end else begin
                        r_bin_data <= w_alu_res;
                        r_done     <= 1'b1;
                        r_state    <= ST_RESULT;
                    end
                end
            end
        end
    end

    assign bin_data = r_bin_data;
    assign busy     = w_div_busy;
    assign err      = r_err;
    assign done     = r_done;

endmodule

`default_nettype wire
